uart_apb_host_ctrl: RTL
=======================

Name: uart_apb_host_ctrl

Overview:
- APB3 master that owns the UART APB slave (register map below).
- After reset it programs the baud and frame control registers once, then runs a polling loop on the status register.
- It moves received bytes to a single consumer stream and arbitrates transmit bytes from NUM_REQ requesters onto the UART TX data register.
- It sits between on-chip byte producers/consumers and the UART, so no CPU is needed on the serial path.

Parameters:
- NUM_REQ, 2, number of TX requesters (1..8).
- BAUD_VALUE, 13'd0, 13-bit baud divisor written at init.
- BIT8, 1'b1, 1 = 8 data bits, 0 = 7.
- PARITY_EN, 1'b0, parity enable written at init.
- ODD_N_EVEN, 1'b0, 1 = odd parity.

Ports:
- PCLK  in  1  clock
- PRESETN  in  1  synchronous active-low reset
- PADDR  out  5  APB address (slave decodes [4:2])
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB write
- PWDATA  out  8  APB write data
- PRDATA  in  8  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error (counted, not retried)
- req_valid  in  NUM_REQ  TX byte pending per requester
- req_data  in  8*NUM_REQ  TX bytes; requester i owns [8i+7:8i]
- req_ack  out  NUM_REQ  1-cycle pulse: byte i has been written to the UART
- rx_data  out  8  received byte
- rx_valid  out  1  rx_data valid; held until accepted
- rx_ready  in  1  consumer accepts when rx_valid & rx_ready
- err_flags  out  3  sticky {FRAMING, OVERFLOW, PARITY}
- err_clr  in  1  clears err_flags
- init_done  out  1  high once init writes are complete
- slverr_cnt  out  8  saturating count of PSLVERR responses

Behaviour:
- Interface: one clock, PCLK. Reset is PRESETN: synchronous, active-low, sampled on the PCLK rising edge.
- Reset values: all APB outputs 0, req_ack 0, rx_valid 0, rx_data 0, err_flags 0, init_done 0, slverr_cnt 0; round-robin pointer = 0; FSM in INIT_C1.
- UART slave register map (byte addresses):
  - 0x00 TX data (write)
  - 0x04 RX data (read)
  - 0x08 CTRL1 = baud[7:0]
  - 0x0C CTRL2 = {baud[12:8], ODD_N_EVEN, PARITY_EN, BIT8}
  - 0x10 STATUS = {3'b0, FRAMING, OVERFLOW, PARITY, RXRDY, TXRDY}
- APB transfer timing:
  - Setup cycle: PSEL=1, PENABLE=0; address, PWRITE and PWDATA valid.
  - Access cycle: PSEL=1, PENABLE=1; held while PREADY=0.
  - Completion: the transfer completes on the edge where PENABLE & PREADY; PRDATA is captured on that edge.
  - Gap: after completion, PSEL=0 for one idle cycle before the next setup. Minimum 3 cycles per transfer.
- FSM states:
  - INIT_C1 (write 0x08) -> INIT_C2 (write 0x0C) -> POLL.
  - POLL: read 0x10.
  - After POLL, with status captured into S:
    - S[4:2] are ORed into err_flags.
    - If S[1] & !rx_valid -> RX_RD (read 0x04): rx_data <= PRDATA and rx_valid <= 1 on completion.
    - Else if S[0] & |req_valid -> TX_WR: the granted requester's byte is written to 0x00; req_ack[g] pulses on the completion edge.
    - Else -> POLL.
  - RX_RD and TX_WR both return to POLL.
- init_done rises on INIT_C2 completion and stays high until reset.
- RX has priority over TX, to limit UART overflow.
- An RX byte is never read while rx_valid is pending; the UART overflows instead, and this is reported via err_flags[1].
- Grant g is latched at the POLL->TX_WR decision. A requester that drops req_valid mid-transfer still gets its ack. req_data[g] is sampled at the setup cycle.
- err_clr and a new error set in the same cycle: set wins.
- Accept (rx_valid & rx_ready) and an RX_RD completion in the same cycle cannot occur, because of the !rx_valid gate.
- PSLVERR=1 on completion: slverr_cnt increments and saturates at 255; the FSM proceeds normally (TX ack is still issued).
- Reset asserted mid-transfer: PSEL and PENABLE drop on the next edge, and init reruns.

Optional Feature:
- Macro: UART_HOST_CTRL_RR_EN.
- Defined: round-robin arbitration. The search starts at the requester after the last granted one (wrapping NUM_REQ-1 -> 0). The pointer updates only on TX_WR completion.
- Undefined: fixed priority; the lowest requester index wins, and no pointer register exists.

Decomposition:
- Package uart_host_pkg holds:
  - Register address localparams (0x00/0x04/0x08/0x0C/0x10).
  - STATUS bit indices.
  - FSM state enum (INIT_C1, INIT_C2, IDLE_GAP, POLL, RX_RD, TX_WR).
- One sub-module: uart_host_arb. It is purely the requester arbiter (req_valid, pointer, feature macro) and outputs a one-hot/index grant.

Test Plan:
1. Reset and init: BAUD_VALUE=13'h1A5, BIT8=1, PARITY_EN=1, ODD=1.
   -> Writes 0x08=0xA5, then 0x0C=0x0F; init_done=1; then a read of 0x10 follows.
2. RX path: STATUS=0x02, RX=0x5A, rx_ready=0 for 10 cycles.
   -> rx_data=0x5A, rx_valid held; no further read of 0x04 until accept; the next POLL sees RXRDY and reads after accept.
3. TX round-robin (RR_EN defined): req_valid=2'b11, data 0x11/0x22, TXRDY=1.
   -> Writes to 0x00 are 0x11, 0x22, 0x11 alternating; req_ack pulses match. With RR_EN undefined: 0x11 only.
4. Priority: STATUS=0x03 with req_valid=1.
   -> A read of 0x04 precedes the write of 0x00.
5. Errors: STATUS=0x1C once.
   -> err_flags=3'b111. Then err_clr -> 0. err_clr in the same cycle as a capture of STATUS=0x04 -> 3'b001.
6. Wait states: PREADY=0 for 4 cycles on TX_WR, with PSLVERR=1.
   -> PENABLE held for 5 cycles; slverr_cnt=1; ack is still issued. Reset during the stall -> PSEL=0 next cycle and init restarts.

Source files
------------

// File: rtl/uart_host_pkg.sv
// Shared definitions for the UART APB host controller: slave register map,
// STATUS bit positions and controller FSM states.
// Optional feature macro: UART_HOST_CTRL_RR_EN (round-robin TX arbitration).
package uart_host_pkg;

   // UART slave byte addresses
   localparam logic [4:0] AddrTx     = 5'h00;
   localparam logic [4:0] AddrRx     = 5'h04;
   localparam logic [4:0] AddrCtrl1  = 5'h08;
   localparam logic [4:0] AddrCtrl2  = 5'h0C;
   localparam logic [4:0] AddrStatus = 5'h10;

   // STATUS register bit indices
   localparam int unsigned StatTxRdy    = 0;
   localparam int unsigned StatRxRdy    = 1;
   localparam int unsigned StatParity   = 2;
   localparam int unsigned StatOverflow = 3;
   localparam int unsigned StatFraming  = 4;

   typedef enum logic [2:0] {
      StInitC1,
      StInitC2,
      StIdleGap,
      StPoll,
      StRxRd,
      StTxWr
   } state_t;

endpackage

// File: rtl/uart_host_arb.sv
// TX requester arbiter. Fixed priority (lowest index wins) by default; with
// UART_HOST_CTRL_RR_EN defined, round-robin starting after the last grant.
module uart_host_arb #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IdxW    = 1
) (
`ifdef UART_HOST_CTRL_RR_EN
   input  logic                PCLK,
   input  logic                PRESETN,
   input  logic                upd_i,
   input  logic [IdxW-1:0]     upd_idx_i,
`endif
   input  logic [NUM_REQ-1:0]  req_valid_i,
   output logic [IdxW-1:0]     gnt_idx_o,
   output logic                gnt_any_o
);

`ifdef UART_HOST_CTRL_RR_EN
   logic [IdxW-1:0] ptr_q, ptr_d;

   // Pointer moves to the requester after the one just served
   always_comb begin
      ptr_d = ptr_q;
      if (upd_i) begin
         ptr_d = (32'(upd_idx_i) == NUM_REQ - 1) ? '0 : upd_idx_i + 1'b1;
      end
   end

   // Pointer register
   always_ff @(posedge PCLK) begin
      if (!PRESETN) ptr_q <= '0;
      else          ptr_q <= ptr_d;
   end

   // First pass covers ptr..N-1; the second pass then finds the wrapped winner
   always_comb begin
      gnt_idx_o = '0;
      gnt_any_o = 1'b0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (!gnt_any_o && req_valid_i[j] && (j >= 32'(ptr_q))) begin
            gnt_any_o = 1'b1;
            gnt_idx_o = IdxW'(j);
         end
      end
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (!gnt_any_o && req_valid_i[j]) begin
            gnt_any_o = 1'b1;
            gnt_idx_o = IdxW'(j);
         end
      end
   end
`else
   // Lowest valid index wins
   always_comb begin
      gnt_idx_o = '0;
      gnt_any_o = 1'b0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (!gnt_any_o && req_valid_i[j]) begin
            gnt_any_o = 1'b1;
            gnt_idx_o = IdxW'(j);
         end
      end
   end
`endif

endmodule

// File: rtl/uart_apb_host_ctrl.sv
// APB3 master driving a UART slave: one-time init of baud/frame control, then
// a STATUS polling loop that forwards RX bytes to one consumer and writes TX
// bytes from NUM_REQ arbitrated requesters.
// Optional feature macro: UART_HOST_CTRL_RR_EN (round-robin TX arbitration).
module uart_apb_host_ctrl
   import uart_host_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 2,
   parameter logic [12:0] BAUD_VALUE = 13'd0,
   parameter logic        BIT8       = 1'b1,
   parameter logic        PARITY_EN  = 1'b0,
   parameter logic        ODD_N_EVEN = 1'b0
) (
   input  logic                   PCLK,
   input  logic                   PRESETN,
   output logic [4:0]             PADDR,
   output logic                   PSEL,
   output logic                   PENABLE,
   output logic                   PWRITE,
   output logic [7:0]             PWDATA,
   input  logic [7:0]             PRDATA,
   input  logic                   PREADY,
   input  logic                   PSLVERR,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]     req_ack,
   output logic [7:0]             rx_data,
   output logic                   rx_valid,
   input  logic                   rx_ready,
   output logic [2:0]             err_flags,
   input  logic                   err_clr,
   output logic                   init_done,
   output logic [7:0]             slverr_cnt
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t              state_q, state_d, ret_q, ret_d, tgt;
   logic                psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
   logic [4:0]          paddr_q, paddr_d;
   logic [7:0]          pwdata_q, pwdata_d, rx_data_q, rx_data_d, slverr_q, slverr_d, tx_byte;
   logic [IdxW-1:0]     gnt_q, gnt_d, gnt_idx;
   logic                gnt_any;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic                rx_valid_q, rx_valid_d, init_done_q, init_done_d;
   logic [2:0]          err_q, err_d;

   uart_host_arb #(
      .NUM_REQ (NUM_REQ),
      .IdxW    (IdxW)
   ) u_arb (
`ifdef UART_HOST_CTRL_RR_EN
      .PCLK        (PCLK),
      .PRESETN     (PRESETN),
      .upd_i       (psel_q & penable_q & PREADY & (state_q == StTxWr)),
      .upd_idx_i   (gnt_q),
`endif
      .req_valid_i (req_valid),
      .gnt_idx_o   (gnt_idx),
      .gnt_any_o   (gnt_any)
   );

   // Next-state: setup when PSEL is low, then access until PREADY, then one gap cycle
   always_comb begin
      state_d     = state_q;
      ret_d       = ret_q;
      gnt_d       = gnt_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      ack_d       = '0;
      rx_valid_d  = rx_valid_q & ~rx_ready;
      rx_data_d   = rx_data_q;
      err_d       = err_clr ? 3'b000 : err_q;
      init_done_d = init_done_q;
      slverr_d    = slverr_q;
      tgt         = (state_q == StIdleGap) ? ret_q : state_q;
      tx_byte     = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt_q == IdxW'(i)) tx_byte = req_data[8*i +: 8];
      end

      if (!psel_q) begin
         state_d   = tgt;
         psel_d    = 1'b1;
         penable_d = 1'b0;
         unique case (tgt)
            StInitC1: begin
               paddr_d = AddrCtrl1; pwrite_d = 1'b1; pwdata_d = BAUD_VALUE[7:0];
            end
            StInitC2: begin
               paddr_d  = AddrCtrl2; pwrite_d = 1'b1;
               pwdata_d = {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8};
            end
            StRxRd: begin
               paddr_d = AddrRx; pwrite_d = 1'b0; pwdata_d = '0;
            end
            StTxWr: begin
               paddr_d = AddrTx; pwrite_d = 1'b1; pwdata_d = tx_byte;
            end
            default: begin
               paddr_d = AddrStatus; pwrite_d = 1'b0; pwdata_d = '0;
            end
         endcase
      end else if (!penable_q) begin
         penable_d = 1'b1;
      end else if (PREADY) begin
         psel_d    = 1'b0;
         penable_d = 1'b0;
         pwrite_d  = 1'b0;
         state_d   = StIdleGap;
         ret_d     = StPoll;
         if (PSLVERR && (slverr_q != 8'hFF)) slverr_d = slverr_q + 8'd1;
         unique case (state_q)
            StInitC1: ret_d = StInitC2;
            StInitC2: init_done_d = 1'b1;
            StPoll: begin
               // Error set wins over a simultaneous clear
               err_d = err_d | PRDATA[StatFraming:StatParity];
               if (PRDATA[StatRxRdy] && !rx_valid_q) begin
                  ret_d = StRxRd;
               end else if (PRDATA[StatTxRdy] && gnt_any) begin
                  ret_d = StTxWr;
                  gnt_d = gnt_idx;
               end
            end
            StRxRd: begin
               rx_data_d  = PRDATA;
               rx_valid_d = 1'b1;
            end
            StTxWr: begin
               for (int unsigned i = 0; i < NUM_REQ; i++) ack_d[i] = (gnt_q == IdxW'(i));
            end
            default: ;
         endcase
      end
   end

   // Controller state and registered outputs
   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         state_q     <= StInitC1;
         ret_q       <= StPoll;
         gnt_q       <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         ack_q       <= '0;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= '0;
         err_q       <= '0;
         init_done_q <= 1'b0;
         slverr_q    <= '0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         gnt_q       <= gnt_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         ack_q       <= ack_d;
         rx_valid_q  <= rx_valid_d;
         rx_data_q   <= rx_data_d;
         err_q       <= err_d;
         init_done_q <= init_done_d;
         slverr_q    <= slverr_d;
      end
   end

   assign PSEL       = psel_q;
   assign PENABLE    = penable_q;
   assign PWRITE     = pwrite_q;
   assign PADDR      = paddr_q;
   assign PWDATA     = pwdata_q;
   assign req_ack    = ack_q;
   assign rx_valid   = rx_valid_q;
   assign rx_data    = rx_data_q;
   assign err_flags  = err_q;
   assign init_done  = init_done_q;
   assign slverr_cnt = slverr_q;

endmodule
